// File: rtl/team_wb_pkg.sv
// team_wb_pkg
//   Shared constants for the team wishbone register slave: default widths,
//   the register offsets (AW-bit), and the decoder's register-select enum.
package team_wb_pkg;

    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 32;
    localparam int PRESC_W_DEF = 14;
    localparam int N_IRQ_DEF   = 1;

    localparam logic [AW_DEF-1:0] EN_OFF    = 16'h0000;
    localparam logic [AW_DEF-1:0] PRESC_OFF = 16'h0004;
    localparam logic [AW_DEF-1:0] IM_OFF    = 16'hFF00;
    localparam logic [AW_DEF-1:0] MIS_OFF   = 16'hFF04;
    localparam logic [AW_DEF-1:0] RIS_OFF   = 16'hFF08;
    localparam logic [AW_DEF-1:0] IC_OFF    = 16'hFF0C;

    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_EN    = 3'd1,
        SEL_PRESC = 3'd2,
        SEL_IM    = 3'd3,
        SEL_MIS   = 3'd4,
        SEL_RIS   = 3'd5,
        SEL_IC    = 3'd6
    } reg_sel_e;

endpackage

// File: rtl/team_wb_reg_slave_irq_flag_bank.sv
// irq_flag_bank
//   Per-source sticky raw flags (RIS), the mask register (IM), write-1-to-clear
//   (IC) handling, the masked status (MIS) and the irq line.
// Ports
//   clk_i, rst_i   clock, async active-high reset
//   evt_i          one-cycle event pulses, one per source
//   im_we_i        write strobe for IM (already qualified by the request)
//   ic_we_i        write strobe for IC
//   wdata_i        write data, low N_IRQ bits
//   wmask_i        byte-lane mask expanded to bits, low N_IRQ bits
//   im_o/ris_o/mis_o  register views for readback
//   irq_o          OR of MIS
module irq_flag_bank #(
    parameter int N_IRQ = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] evt_i,
    input  logic             im_we_i,
    input  logic             ic_we_i,
    input  logic [N_IRQ-1:0] wdata_i,
    input  logic [N_IRQ-1:0] wmask_i,
    output logic [N_IRQ-1:0] im_o,
    output logic [N_IRQ-1:0] ris_o,
    output logic [N_IRQ-1:0] mis_o,
    output logic             irq_o
);

    logic [N_IRQ-1:0] im_q, im_d;
    logic [N_IRQ-1:0] ris_q, ris_d;

    for (genvar k = 0; k < N_IRQ; k++) begin : g_src
        logic clr;
        assign clr      = ic_we_i & wdata_i[k] & wmask_i[k];
        // Event is OR'd in after the clear so a coincident event wins.
        assign ris_d[k] = (ris_q[k] & ~clr) | evt_i[k];
        assign im_d[k]  = (im_we_i & wmask_i[k]) ? wdata_i[k] : im_q[k];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            im_q  <= '0;
            ris_q <= '0;
        end else begin
            im_q  <= im_d;
            ris_q <= ris_d;
        end
    end

    assign im_o  = im_q;
    assign ris_o = ris_q;
    assign mis_o = ris_q & im_q;
    assign irq_o = |mis_o;

endmodule

// File: rtl/team_wb_reg_slave.sv
// team_wb_reg_slave
//   Wishbone classic slave for the team core: EN and PRESCALER control
//   registers plus the IM/MIS/RIS/IC interrupt block. Fixed one-cycle ack,
//   byte-lane writes, zero-extended registered reads, unmapped offsets are
//   acked and read as zero.
// Ports
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   wbs_stb/cyc/we/sel/adr/dat_i  wishbone request
//   wbs_dat_o, wbs_ack_o      registered response (dat_o is 0 when ack is 0)
//   evt_i                     core event pulses
//   en_o, prescaler_o, irq    outputs to/from the core
module team_wb_reg_slave
    import team_wb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int PRESC_W = PRESC_W_DEF,
    parameter int N_IRQ   = N_IRQ_DEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [DW-1:0]      wbs_dat_i,
    output logic [DW-1:0]      wbs_dat_o,
    output logic               wbs_ack_o,
    input  logic [N_IRQ-1:0]   evt_i,
    output logic               en_o,
    output logic [PRESC_W-1:0] prescaler_o,
    output logic               irq
);

    logic               ack_q, ack_d;
    logic [DW-1:0]      dat_q, dat_d;
    logic               en_q, en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;

    logic               req, wr;
    reg_sel_e           sel;
    logic [DW-1:0]      wmask;
    logic [DW-1:0]      rdata;
    logic [N_IRQ-1:0]   im, ris, mis;

    // A new request only when no ack is outstanding, so a held strobe
    // cannot be acked on two consecutive edges.
    assign req = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr  = req & wbs_we_i;

    always_comb begin
        sel = SEL_NONE;
        case (wbs_adr_i[AW-1:0])
            AW'(EN_OFF):    sel = SEL_EN;
            AW'(PRESC_OFF): sel = SEL_PRESC;
            AW'(IM_OFF):    sel = SEL_IM;
            AW'(MIS_OFF):   sel = SEL_MIS;
            AW'(RIS_OFF):   sel = SEL_RIS;
            AW'(IC_OFF):    sel = SEL_IC;
            default:        sel = SEL_NONE;
        endcase
    end

    always_comb begin
        wmask = '0;
        for (int i = 0; i < DW; i++) wmask[i] = wbs_sel_i[i/8];
    end

    always_comb begin
        en_d    = en_q;
        presc_d = presc_q;
        if (wr && sel == SEL_EN && wmask[0]) en_d = wbs_dat_i[0];
        if (wr && sel == SEL_PRESC)
            presc_d = (presc_q & ~wmask[PRESC_W-1:0])
                    | (wbs_dat_i[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
    end

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_EN:    rdata[0]         = en_q;
            SEL_PRESC: rdata[PRESC_W-1:0] = presc_q;
            SEL_IM:    rdata[N_IRQ-1:0] = im;
            SEL_MIS:   rdata[N_IRQ-1:0] = mis;
            SEL_RIS:   rdata[N_IRQ-1:0] = ris;
            default:   rdata            = '0;
        endcase
    end

    assign ack_d = req;
    assign dat_d = (req && !wbs_we_i) ? rdata : '0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            en_q    <= 1'b0;
            presc_q <= '0;
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            en_q    <= en_d;
            presc_q <= presc_d;
        end
    end

    irq_flag_bank #(.N_IRQ(N_IRQ)) u_irq (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .evt_i   (evt_i),
        .im_we_i (wr && sel == SEL_IM),
        .ic_we_i (wr && sel == SEL_IC),
        .wdata_i (wbs_dat_i[N_IRQ-1:0]),
        .wmask_i (wmask[N_IRQ-1:0]),
        .im_o    (im),
        .ris_o   (ris),
        .mis_o   (mis),
        .irq_o   (irq)
    );

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign en_o        = en_q;
    assign prescaler_o = presc_q;

    // Upper address bits are not decoded.
    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[31:AW];

endmodule

// File: tb/tb_team_wb_reg_slave.sv
module tb_team_wb_reg_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic [31:0] rdat;
    logic        ack;
    logic [0:0]  evt = 1'b0;
    logic        en;
    logic [13:0] presc;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    team_wb_reg_slave dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_dat_o   (rdat),
        .wbs_ack_o   (ack),
        .evt_i       (evt),
        .en_o        (en),
        .prescaler_o (presc),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A_EN = 32'h0000, A_PR = 32'h0004, A_IM = 32'hFF00;
    localparam logic [31:0] A_MIS = 32'hFF04, A_RIS = 32'hFF08, A_IC = 32'hFF0C;

    // One single access: drive at negedge, drop strobe just after the sampling
    // edge, then sample ack/data on the next two negedges.
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic ack1, output logic ack2);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = a; wdat = d;
        @(posedge clk);
        #1 stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        ack1 = ack; rd = rdat;
        @(negedge clk);
        ack2 = ack;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic a1, a2;
        logic [31:0] offs [6] = '{A_EN, A_PR, A_IM, A_MIS, A_RIS, A_IC};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if ({ack, rdat, en, presc, irq} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ack=%b dat=0x%0h en=%b presc=0x%0h irq=%b expected all 0",
                     ack, rdat, en, presc, irq);
        end
        vectors++;
        rst = 1'b0;
        foreach (offs[i]) begin
            wb_xfer(offs[i], 1'b0, 4'hF, 32'h0, rd, a1, a2);
            check($sformatf("reset_read_%0h", offs[i]), rd, 32'h0);
            check("reset_read_ack", {31'b0, a1}, 32'h1);
        end
    endtask

    task automatic test_control_rw();
        logic [31:0] rd; logic a1, a2;
        wb_xfer(A_PR, 1'b1, 4'hF, 32'h1, rd, a1, a2);
        check("presc_wr_ack", {30'b0, a1, a2}, 32'h2);
        wb_xfer(A_EN, 1'b1, 4'hF, 32'h1, rd, a1, a2);
        check("en_wr_ack", {30'b0, a1, a2}, 32'h2);
        check("prescaler_o", {18'b0, presc}, 32'h1);
        check("en_o", {31'b0, en}, 32'h1);
        wb_xfer(A_PR, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("presc_rd", rd, 32'h1);
        check("presc_rd_ack", {30'b0, a1, a2}, 32'h2);
        wb_xfer(A_EN, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("en_rd", rd, 32'h1);
        check("en_rd_ack", {30'b0, a1, a2}, 32'h2);
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic a1, a2;
        // Upper bits of 0xFFFFFFFF beyond 14 are dropped.
        wb_xfer(A_PR, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, a1, a2);
        wb_xfer(A_PR, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("presc_trunc", rd, 32'h3FFF);
        wb_xfer(A_PR, 1'b1, 4'b0001, 32'h0, rd, a1, a2);
        wb_xfer(A_PR, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("presc_lane0", rd, 32'h3F00);
        wb_xfer(A_EN, 1'b1, 4'b0010, 32'h0, rd, a1, a2);
        check("en_lane_masked", {31'b0, en}, 32'h1);
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; logic a1, a2;
        wb_xfer(32'h0010, 1'b1, 4'hF, 32'hDEAD, rd, a1, a2);
        check("unmapped_wr_ack", {30'b0, a1, a2}, 32'h2);
        check("unmapped_no_change", {17'b0, en, presc}, {17'b0, 1'b1, 14'h3F00});
        wb_xfer(32'h0010, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("unmapped_rd", rd, 32'h0);
        check("unmapped_rd_ack", {31'b0, a1}, 32'h1);
        wb_xfer(A_IC, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("ic_reads_0", rd, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [2:0] seen;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = A_PR;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen[i] = ack;
        end
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        check("held_stb_ack_pattern", {29'b0, seen}, 32'b101);
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic a1, a2;
        wb_xfer(A_IM, 1'b1, 4'hF, 32'h1, rd, a1, a2);
        @(negedge clk); evt = 1'b1;
        check("irq_before_edge", {31'b0, irq}, 32'h0);
        @(negedge clk); evt = 1'b0;
        check("irq_rise", {31'b0, irq}, 32'h1);
        wb_xfer(A_RIS, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("ris_set", rd, 32'h1);
        wb_xfer(A_MIS, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("mis_set", rd, 32'h1);
        wb_xfer(A_IC, 1'b1, 4'hF, 32'h1, rd, a1, a2);
        check("irq_fall", {31'b0, irq}, 32'h0);
        wb_xfer(A_RIS, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("ris_cleared", rd, 32'h0);
        // Masked: event recorded, no irq.
        wb_xfer(A_IM, 1'b1, 4'hF, 32'h0, rd, a1, a2);
        @(negedge clk); evt = 1'b1;
        @(negedge clk); evt = 1'b0;
        check("irq_masked", {31'b0, irq}, 32'h0);
        wb_xfer(A_RIS, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("ris_masked_set", rd, 32'h1);
        wb_xfer(A_MIS, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("mis_masked", rd, 32'h0);
        wb_xfer(A_IC, 1'b1, 4'hF, 32'h1, rd, a1, a2);
    endtask

    task automatic test_evt_vs_ic();
        logic [31:0] rd; logic a1, a2;
        wb_xfer(A_IM, 1'b1, 4'hF, 32'h1, rd, a1, a2);
        @(negedge clk); evt = 1'b1;
        @(negedge clk); evt = 1'b0;
        // IC write and a fresh event on the same edge.
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; adr = A_IC; wdat = 32'h1; evt = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0; cyc = 1'b0; we = 1'b0; evt = 1'b0;
        @(negedge clk);
        check("coincident_irq", {31'b0, irq}, 32'h1);
        wb_xfer(A_RIS, 1'b0, 4'hF, 32'h0, rd, a1, a2);
        check("coincident_ris", rd, 32'h1);
        wb_xfer(A_IC, 1'b1, 4'hF, 32'h1, rd, a1, a2);
        check("final_clear_irq", {31'b0, irq}, 32'h0);
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'hF; adr = A_PR; wdat = 32'h55;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ack", {31'b0, ack}, 32'h0);
        check("rst_mid_presc", {18'b0, presc}, 32'h0);
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ack", {31'b0, ack}, 32'h0);
        check("post_rst_presc", {18'b0, presc}, 32'h0);
    endtask

    initial begin
        test_reset();
        test_control_rw();
        test_byte_lanes();
        test_unmapped();
        test_back_to_back();
        test_irq();
        test_evt_vs_ic();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
